fetch_seq: RTL

Fetch sequencer for the front end: owns the fetch PC, issues in-order requests to the I-cache, buffers returned instructions in a small queue, and hands them to decode under a valid/ready handshake. Sits between the backend redirect source, the I-cache fetch port and the decode stage; replaces the pass-through path in the fetch top level. Handles redirects by flushing buffered instructions and discarding in-flight responses before fetching from the new PC.

---
 rtl/fetch_pkg.sv | 20 ++
 rtl/fetch_inst_queue.sv | 92 +++++++++
 rtl/fetch_seq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared front-end fetch definitions: sequencer states, queue entry layout
// and the fixed instruction size used to step the fetch PC.
package fetch_pkg;

    localparam int ADDR_W     = 32;
    localparam int INST_W     = 32;
    localparam int INST_BYTES = 4;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_inst_queue.sv
// Small instruction FIFO between the I-cache response port and decode.
// Push and pop may coincide at any occupancy (including full); flush wins
// over both. The head entry is read straight out of the slot registers.
module fetch_inst_queue
    import fetch_pkg::*;
#(
    parameter int QDEPTH = 2,
    localparam int CW = $clog2(QDEPTH + 1),
    localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1
) (
    input  logic          clk,
    input  logic          reset_,
    input  logic          flush,
    input  logic          push,
    input  logic          pop,
    input  fetch_entry_t  push_entry,
    output fetch_entry_t  head,
    output logic          head_valid,
    output logic [CW-1:0] count
);

    localparam logic [PW-1:0] PONE = PW'(1);
    localparam logic [CW-1:0] CONE = CW'(1);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;
    fetch_entry_t  slots [QDEPTH];

    // Pointer and occupancy update; pointers wrap naturally (depth is a power of 2)
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_push  = push && !flush;
        do_pop   = pop && (count_q != '0) && !flush;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PONE;
            if (do_push && !do_pop)      count_d = count_q + CONE;
            else if (!do_push && do_pop) count_d = count_q - CONE;
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_slot
        fetch_entry_t slot_q, slot_d;

        // A slot loads only when the write pointer targets it
        always_comb begin
            slot_d = slot_q;
            if (do_push && (wr_ptr_q == PW'(gi))) slot_d = push_entry;
        end

        // Slot storage; cleared on reset so the head reads zero out of reset
        always_ff @(posedge clk or negedge reset_) begin
            if (!reset_) slot_q <= '0;
            else         slot_q <= slot_d;
        end

        assign slots[gi] = slot_q;
    end

    assign head       = slots[rd_ptr_q];
    assign head_valid = (count_q != '0);
    assign count      = count_q;

    // The sequencer's credit scheme must never push into a full queue
    // unless the head leaves in the same cycle.
    assert property (@(posedge clk) disable iff (!reset_)
        (push && !flush) |-> ((count_q < CW'(QDEPTH)) || pop))
        else $error("fetch_inst_queue: push into full queue");

endmodule

// File: rtl/fetch_seq.sv
// Fetch sequencer: owns the fetch PC, issues in-order I-cache requests under
// a credit limit, buffers responses in fetch_inst_queue and presents the head
// to decode. Redirects flush the queue and discard responses still in flight.
// ADDR/INST must match the widths of fetch_entry_t in fetch_pkg.
module fetch_seq
    import fetch_pkg::*;
#(
    parameter int              ADDR     = ADDR_W,
    parameter int              INST     = INST_W,
    parameter logic [ADDR-1:0] RESET_PC = '0,
    parameter int              QDEPTH   = 2
) (
    input  logic            clk,
    input  logic            reset_,
    input  logic            redirect_valid,
    input  logic [ADDR-1:0] redirect_pc,
    output logic            ic_req,
    output logic [ADDR-1:0] ic_req_pc,
    input  logic            ic_req_ready,
    input  logic            ic_resp_valid,
    input  logic [INST-1:0] ic_resp_inst,
    input  logic [ADDR-1:0] ic_resp_pc,
    output logic            dec_valid,
    output logic [ADDR-1:0] dec_pc,
    output logic [INST-1:0] dec_inst,
    input  logic            dec_ready
);

    localparam int              CW         = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0]   ONE        = CW'(1);
    localparam logic [CW:0]     CREDITS    = (CW + 1)'(QDEPTH);
    localparam logic [ADDR-1:0] PC_STEP    = ADDR'(INST_BYTES);
    localparam logic [ADDR-1:0] ALIGN_MASK = ~ADDR'(INST_BYTES - 1);

    fetch_state_e    state_q, state_d;
    logic [ADDR-1:0] pc_q, pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;

    logic [CW:0]     in_use;
    logic            accept;
    logic            resp_take;
    logic            q_push;
    logic            q_pop;
    logic [CW-1:0]   q_count;
    logic            q_head_valid;
    fetch_entry_t    q_head;
    fetch_entry_t    resp_entry;

    assign resp_entry.pc   = ic_resp_pc;
    assign resp_entry.inst = ic_resp_inst;

    // Next-state, PC, credit accounting and request/queue controls. The credit
    // check counts the queued head even when decode is popping it, so ic_req
    // never depends on dec_ready.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        outstanding_d = outstanding_q;
        in_use        = {1'b0, outstanding_q} + {1'b0, q_count};
        resp_take     = ic_resp_valid && (outstanding_q != '0);
        ic_req        = (state_q == RUN) && !redirect_valid && (in_use < CREDITS);
        accept        = ic_req && ic_req_ready;
        q_pop         = q_head_valid && dec_ready;
        q_push        = resp_take && (state_q == RUN) && !redirect_valid;

        if (accept && !resp_take)      outstanding_d = outstanding_q + ONE;
        else if (!accept && resp_take) outstanding_d = outstanding_q - ONE;

        if (redirect_valid) begin
            // Stale responses still have to come back before the new stream starts
            pc_d    = redirect_pc & ALIGN_MASK;
            state_d = (outstanding_d != '0) ? DRAIN : RUN;
        end else begin
            if (accept) pc_d = pc_q + PC_STEP;
            unique case (state_q)
                BOOT:    begin
                    pc_d    = RESET_PC;
                    state_d = RUN;
                end
                RUN:     state_d = RUN;
                DRAIN:   if (outstanding_d == '0) state_d = RUN;
                default: state_d = BOOT;
            endcase
        end
    end

    // Sequencer state, fetch PC and in-flight counter
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
        end
    end

    fetch_inst_queue #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk        (clk),
        .reset_     (reset_),
        .flush      (redirect_valid),
        .push       (q_push),
        .pop        (q_pop),
        .push_entry (resp_entry),
        .head       (q_head),
        .head_valid (q_head_valid),
        .count      (q_count)
    );

    assign ic_req_pc = pc_q;
    assign dec_valid = q_head_valid;
    assign dec_pc    = q_head.pc;
    assign dec_inst  = q_head.inst;

    // A response with nothing in flight is an I-cache protocol violation; it is dropped
    assert property (@(posedge clk) disable iff (!reset_)
        ic_resp_valid |-> (outstanding_q != '0))
        else $error("fetch_seq: I-cache response with nothing outstanding");

endmodule
